// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the MIPS unified-memory arbiter slice.
package mips_mem_pkg;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;
   localparam int ARB_WAIT_W = 4;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LDR = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_WAIT   = 2'd2,
      ARB_DONE   = 2'd3
   } arb_state_e;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter; slave = arbiter view, master = environment view.
interface mips_mem_arbiter_if #(
   parameter int ADDR_W = mips_mem_pkg::ARB_ADDR_W,
   parameter int DATA_W = mips_mem_pkg::ARB_DATA_W
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;

   logic              ldr_req;
   logic              ldr_we;
   logic [ADDR_W-1:0] ldr_addr;
   logic [DATA_W-1:0] ldr_wdata;
   logic [DATA_W-1:0] ldr_rdata;
   logic              ldr_ack;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;

   logic              owner;
   logic              busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
      output ldr_rdata, ldr_ack,
      output mem_addr, mem_wdata, mem_we, mem_re,
      input  mem_rdata,
      output owner, busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata,
      input  ldr_rdata, ldr_ack,
      input  mem_addr, mem_wdata, mem_we, mem_re,
      output mem_rdata,
      input  owner, busy
   );
endinterface

// File: rtl/mips_mem_rr_pick.sv
// Two-requester round-robin picker (bit 0 = CPU, bit 1 = loader).
// With MIPS_MEM_ARB_LDR_LOCK_EN defined, a lock input makes the loader the only eligible requester.
module mips_mem_rr_pick
   import mips_mem_pkg::*;
(
   input  logic [1:0] req,
   input  owner_e     last_owner,
`ifdef MIPS_MEM_ARB_LDR_LOCK_EN
   input  logic       lock,
`endif
   output logic       grant_valid,
   output owner_e     grant_owner
);

   always_comb begin
      grant_valid = |req;
      grant_owner = OWN_CPU;
      if (req == 2'b11) begin
         grant_owner = (last_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
      end else if (req[1]) begin
         grant_owner = OWN_LDR;
      end
`ifdef MIPS_MEM_ARB_LDR_LOCK_EN
      if (lock) begin
         grant_valid = req[1];
         grant_owner = OWN_LDR;
      end
`endif
   end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Unified memory port arbiter for the multicycle MIPS core: CPU vs. program loader, round-robin.
// Optional MIPS_MEM_ARB_LDR_LOCK_EN adds ldr_lock to give the loader exclusive access.
module mips_mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W      = ARB_ADDR_W,
   parameter int DATA_W      = ARB_DATA_W,
   parameter int WAIT_CYCLES = 1
) (
   input logic clock,
   input logic reset,
`ifdef MIPS_MEM_ARB_LDR_LOCK_EN
   input logic ldr_lock,
`endif
   mips_mem_arbiter_if.slave bus
);

   localparam logic [ARB_WAIT_W-1:0] WAIT_LD = ARB_WAIT_W'(WAIT_CYCLES);
   localparam logic [ARB_WAIT_W-1:0] CNT_ONE = ARB_WAIT_W'(1);

   arb_state_e            state_q, state_d;
   owner_e                owner_q, owner_d;
   owner_e                last_owner_q, last_owner_d;
   logic                  we_q, we_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [ARB_WAIT_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0]     cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]     ldr_rdata_q, ldr_rdata_d;
   logic                  capture;
   logic                  grant_valid;
   owner_e                grant_owner;

   mips_mem_rr_pick u_pick (
      .req         ({bus.ldr_req, bus.cpu_req}),
      .last_owner  (last_owner_q),
`ifdef MIPS_MEM_ARB_LDR_LOCK_EN
      .lock        (ldr_lock),
`endif
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ARB_IDLE;
         owner_q      <= OWN_CPU;
         last_owner_q <= OWN_LDR;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         cpu_rdata_q  <= '0;
         ldr_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         cpu_rdata_q  <= cpu_rdata_d;
         ldr_rdata_q  <= ldr_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      cpu_rdata_d  = cpu_rdata_q;
      ldr_rdata_d  = ldr_rdata_q;
      capture      = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            // Fields are latched here so requester changes later in the transaction are ignored.
            if (grant_valid) begin
               owner_d = grant_owner;
               if (grant_owner == OWN_LDR) begin
                  we_d    = bus.ldr_we;
                  addr_d  = bus.ldr_addr;
                  wdata_d = bus.ldr_wdata;
               end else begin
                  we_d    = bus.cpu_we;
                  addr_d  = bus.cpu_addr;
                  wdata_d = bus.cpu_wdata;
               end
               state_d = ARB_ACCESS;
            end
         end
         ARB_ACCESS: begin
            if (we_q) begin
               state_d = ARB_DONE;
            end else if (WAIT_CYCLES == 0) begin
               capture = 1'b1;
               state_d = ARB_DONE;
            end else begin
               cnt_d   = WAIT_LD;
               state_d = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q <= CNT_ONE) begin
               capture = 1'b1;
               state_d = ARB_DONE;
            end
         end
         ARB_DONE: begin
            last_owner_d = owner_q;
            state_d      = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
      if (capture) begin
         if (owner_q == OWN_LDR) ldr_rdata_d = bus.mem_rdata;
         else                    cpu_rdata_d = bus.mem_rdata;
      end
   end

   assign bus.busy      = (state_q != ARB_IDLE);
   assign bus.owner     = owner_q;
   assign bus.mem_addr  = bus.busy ? addr_q : '0;
   assign bus.mem_wdata = bus.busy ? wdata_q : '0;
   assign bus.mem_we    = (state_q == ARB_ACCESS) && we_q;
   assign bus.mem_re    = ((state_q == ARB_ACCESS) && !we_q) || (state_q == ARB_WAIT);
   assign bus.cpu_ack   = (state_q == ARB_DONE) && (owner_q == OWN_CPU);
   assign bus.ldr_ack   = (state_q == ARB_DONE) && (owner_q == OWN_LDR);
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: WAIT_CYCLES = 1 main instance plus 0 and 3 latency instances.
// Lock scenario runs only when MIPS_MEM_ARB_LDR_LOCK_EN is defined.
module tb_mips_mem_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
   mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

`ifdef MIPS_MEM_ARB_LDR_LOCK_EN
   logic ldr_lock = 1'b0;
   logic lock0    = 1'b0;
   logic lock3    = 1'b0;
`endif

   mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut (
      .clock (clock), .reset (reset),
`ifdef MIPS_MEM_ARB_LDR_LOCK_EN
      .ldr_lock (ldr_lock),
`endif
      .bus (bus)
   );
   mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
      .clock (clock), .reset (reset),
`ifdef MIPS_MEM_ARB_LDR_LOCK_EN
      .ldr_lock (lock0),
`endif
      .bus (b0)
   );
   mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) dut3 (
      .clock (clock), .reset (reset),
`ifdef MIPS_MEM_ARB_LDR_LOCK_EN
      .ldr_lock (lock3),
`endif
      .bus (b3)
   );

   // Word-addressed memory for the main instance; the latency instances see a fixed address pattern.
   logic [31:0] mem [0:15];
   assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
   assign b0.mem_rdata  = b0.mem_addr ^ 32'hA5A5_0000;
   assign b3.mem_rdata  = b3.mem_addr ^ 32'hA5A5_0000;
   always @(posedge clock) if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;

   int n_checks = 0;
   int n_pass   = 0;
   int excl_viol = 0;

   always @(negedge clock) if (bus.mem_we && bus.mem_re) excl_viol++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Runs one transaction for a port (0 = CPU, 1 = loader); called at a negedge with the DUT idle.
   task automatic do_txn(input bit who, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output int re_cnt, output int we_cnt,
                         output logic [31:0] w_addr, output logic [31:0] w_data, output int other_ack);
      bit done = 0;
      lat = 0; rdata = '0; re_cnt = 0; we_cnt = 0; w_addr = '0; w_data = '0; other_ack = 0;
      if (!who) begin
         bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
      end else begin
         bus.ldr_req = 1; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wdata;
      end
      while (!done) begin
         @(negedge clock);
         lat++;
         if (bus.mem_re) re_cnt++;
         if (bus.mem_we) begin we_cnt++; w_addr = bus.mem_addr; w_data = bus.mem_wdata; end
         if (who ? bus.cpu_ack : bus.ldr_ack) other_ack++;
         if (!who && bus.cpu_ack) begin rdata = bus.cpu_rdata; done = 1; end
         if (who && bus.ldr_ack) begin rdata = bus.ldr_rdata; done = 1; end
         if (!done && lat >= 40) begin lat = -1; done = 1; end
      end
      bus.cpu_req = 0; bus.ldr_req = 0;
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, re_c, we_c, oth, ng, dbl, lat0, lat3, re3, acks0, acks3;
      logic [31:0] rd, wa, wd, r0, r3;
      bit who [4];
      int tack [4];
      bit pc, pl;

      mem[4] <= 32'hDEAD_BEEF;
      mem[1] <= 32'h0000_0000;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
      b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = '0; b0.cpu_wdata = '0;
      b0.ldr_req = 0; b0.ldr_we = 0; b0.ldr_addr = '0; b0.ldr_wdata = '0;
      b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
      b3.ldr_req = 0; b3.ldr_we = 0; b3.ldr_addr = '0; b3.ldr_wdata = '0;

      repeat (2) @(negedge clock);
      chk("rst_busy", bus.busy, 0);
      chk("rst_owner", bus.owner, 0);
      chk("rst_acks", {bus.cpu_ack, bus.ldr_ack}, 0);
      chk("rst_strobes", {bus.mem_we, bus.mem_re}, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_rdata", {bus.cpu_rdata, bus.ldr_rdata}, 0);
      reset = 0;
      @(negedge clock);

      // CPU read of 0x10 with one wait cycle
      do_txn(0, 0, 32'h0000_0010, '0, lat, rd, re_c, we_c, wa, wd, oth);
      $display("txn cpu rd 0x10: lat=%0d rdata=0x%08h re_cycles=%0d", lat, rd, re_c);
      chk("cpu_rd_lat", lat, 3);
      chk("cpu_rd_data", rd, 32'hDEAD_BEEF);
      chk("cpu_rd_re_cycles", re_c, 2);
      chk("cpu_rd_we_cycles", we_c, 0);
      chk("cpu_rd_ldr_ack", oth, 0);

      // Loader write, then CPU reads it back
      do_txn(1, 1, 32'h0000_0004, 32'h2008_0005, lat, rd, re_c, we_c, wa, wd, oth);
      $display("txn ldr wr 0x4: lat=%0d we_cycles=%0d addr=0x%08h data=0x%08h", lat, we_c, wa, wd);
      chk("ldr_wr_lat", lat, 2);
      chk("ldr_wr_we_cycles", we_c, 1);
      chk("ldr_wr_addr", wa, 32'h0000_0004);
      chk("ldr_wr_data", wd, 32'h2008_0005);
      chk("ldr_wr_re_cycles", re_c, 0);
      chk("ldr_wr_rdata_held", rd, 0);
      chk("cpu_rdata_held", bus.cpu_rdata, 32'hDEAD_BEEF);
      do_txn(0, 0, 32'h0000_0004, '0, lat, rd, re_c, we_c, wa, wd, oth);
      $display("txn cpu rd 0x4: lat=%0d rdata=0x%08h", lat, rd);
      chk("cpu_rdback_lat", lat, 3);
      chk("cpu_rdback_data", rd, 32'h2008_0005);

      // Both requesters held from reset: CPU first, then strict alternation
      reset = 1; @(negedge clock); reset = 0;
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
      bus.ldr_req = 1; bus.ldr_we = 0; bus.ldr_addr = 32'h04;
      ng = 0; dbl = 0; pc = 0; pl = 0;
      for (int c = 1; c <= 40 && ng < 4; c++) begin
         @(negedge clock);
         if ((bus.cpu_ack && pc) || (bus.ldr_ack && pl) || (bus.cpu_ack && bus.ldr_ack)) dbl++;
         if (bus.cpu_ack) begin who[ng] = 0; tack[ng] = c; ng++; end
         else if (bus.ldr_ack) begin who[ng] = 1; tack[ng] = c; ng++; end
         pc = bus.cpu_ack; pl = bus.ldr_ack;
      end
      bus.cpu_req = 0; bus.ldr_req = 0;
      @(negedge clock);
      $display("txn rr: grants=%0d order=%0d%0d%0d%0d ack_cycles=%0d,%0d", ng, who[0], who[1], who[2], who[3], tack[0], tack[1]);
      chk("rr_count", ng, 4);
      chk("rr_order", {who[0], who[1], who[2], who[3]}, 4'b0101);
      chk("rr_first_ack", tack[0], 3);
      chk("rr_spacing", tack[1] - tack[0], 4);
      chk("rr_single_pulse", dbl, 0);

      // Reset in the WAIT state of a CPU read, CPU keeps requesting
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
      @(negedge clock); @(negedge clock);
      chk("pre_rst_in_wait", {bus.busy, bus.mem_re}, 2'b11);
      #1 reset = 1;
      #1;
      chk("mid_rst_busy_re", {bus.busy, bus.mem_re, bus.mem_we}, 0);
      chk("mid_rst_addr", bus.mem_addr, 0);
      chk("mid_rst_rdata", bus.cpu_rdata, 0);
      @(negedge clock);
      reset = 0;
      lat = -1;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         @(negedge clock);
         if (bus.cpu_ack) begin lat = c; rd = bus.cpu_rdata; end
      end
      bus.cpu_req = 0;
      @(negedge clock);
      $display("txn cpu rd after reset: lat=%0d rdata=0x%08h", lat, rd);
      chk("post_rst_lat", lat, 3);
      chk("post_rst_data", rd, 32'hDEAD_BEEF);

      // Latency of WAIT_CYCLES = 0 and 3 instances
      b0.cpu_req = 1; b0.cpu_addr = 32'h20;
      b3.cpu_req = 1; b3.cpu_addr = 32'h30;
      lat0 = 0; lat3 = 0; re3 = 0; r0 = '0; r3 = '0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clock);
         if (b3.mem_re) re3++;
         if (b0.cpu_ack && lat0 == 0) begin lat0 = c; r0 = b0.cpu_rdata; b0.cpu_req = 0; end
         if (b3.cpu_ack && lat3 == 0) begin lat3 = c; r3 = b3.cpu_rdata; b3.cpu_req = 0; end
      end
      $display("txn wait0 lat=%0d rdata=0x%08h, wait3 lat=%0d rdata=0x%08h re=%0d", lat0, r0, lat3, r3, re3);
      chk("w0_lat", lat0, 2);
      chk("w0_data", r0, 32'hA5A5_0020);
      chk("w3_lat", lat3, 5);
      chk("w3_data", r3, 32'hA5A5_0030);
      chk("w3_re_cycles", re3, 4);

      // Request dropped during ACCESS still completes
      b0.cpu_req = 1; b0.cpu_addr = 32'h40;
      b3.cpu_req = 1; b3.cpu_addr = 32'h40;
      @(negedge clock);
      b0.cpu_req = 0; b0.cpu_addr = 32'h3C;
      b3.cpu_req = 0; b3.cpu_addr = 32'h3C;
      acks0 = 0; acks3 = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         if (b0.cpu_ack) acks0++;
         if (b3.cpu_ack) acks3++;
      end
      $display("txn dropped req: acks wait0=%0d wait3=%0d rdata3=0x%08h", acks0, acks3, b3.cpu_rdata);
      chk("w0_drop_ack", acks0, 1);
      chk("w3_drop_ack", acks3, 1);
      chk("w3_drop_data", b3.cpu_rdata, 32'hA5A5_0040);

`ifdef MIPS_MEM_ARB_LDR_LOCK_EN
      reset = 1; @(negedge clock); reset = 0;
      ldr_lock = 1;
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
      bus.ldr_req = 1; bus.ldr_we = 0; bus.ldr_addr = 32'h04;
      ng = 0; dbl = 0;
      for (int c = 1; c <= 40 && ng < 4; c++) begin
         @(negedge clock);
         if (bus.cpu_ack) dbl++;
         if (bus.ldr_ack) ng++;
      end
      ldr_lock = 0;
      lat = -1;
      for (int c = 1; c <= 10 && lat < 0; c++) begin
         @(negedge clock);
         if (bus.cpu_ack) lat = 0;
         if (bus.ldr_ack) lat = 1;
      end
      bus.cpu_req = 0; bus.ldr_req = 0;
      @(negedge clock);
      $display("txn lock: ldr_grants=%0d cpu_acks=%0d next_owner=%0d", ng, dbl, lat);
      chk("lock_ldr_grants", ng, 4);
      chk("lock_cpu_stalled", dbl, 0);
      chk("unlock_next_cpu", lat, 0);
`endif

      chk("we_re_exclusive", excl_viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Arbitrates the single unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU control path (fetch, lw, sw) and the program loader/debug port.
- Owns the memory port: sequences address, write-enable and read-wait timing, and returns a per-requester ack that the CPU FSM uses as a stall qualifier.
- Sits between the datapath's IorD address mux and the memory macro.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, memory word width.
- WAIT_CYCLES, 1, extra memory read latency cycles, legal range 0..15.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack = 1
- cpu_ack  out  1  one-cycle completion pulse
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack  (same widths and rules as the cpu_* group, for the loader)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read enable
- mem_rdata  in  DATA_W  memory read data
- owner  out  1  0 = CPU, 1 = loader; valid while busy = 1
- busy  out  1  transaction in flight (state != IDLE)

Interface rule: reset reset, asynchronous, active-high; clock clock.

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - state = IDLE.
  - All outputs 0: acks, rdata, mem_* strobes, mem_addr, mem_wdata, owner, busy.
  - last_owner = LDR, so the CPU wins the first tie.
  - Wait counter = 0.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the requester that is not last_owner (strict round-robin).
  - On grant: latch we, addr and wdata into internal registers; set owner; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata driven from the latched registers.
  - Write: mem_we = 1, then go to DONE.
  - Read: mem_re = 1.
    - WAIT_CYCLES = 0: capture mem_rdata at the end of ACCESS, go to DONE.
    - WAIT_CYCLES > 0: load the counter, go to WAIT.
- WAIT:
  - mem_re stays 1; mem_addr is held.
  - Counter decrements once per cycle.
  - When the counter reaches 1, capture mem_rdata and go to DONE.
  - Residency is exactly WAIT_CYCLES cycles.
- DONE (1 cycle):
  - Owner's ack = 1.
  - Owner's rdata holds the captured word on reads; it holds its previous value on writes.
  - last_owner = owner; go to IDLE.
- Latency, req high (sampled in IDLE) to ack:
  - Write: 2 cycles.
  - Read: 2 + WAIT_CYCLES cycles.
- Back-to-back throughput: one transaction every 3 + WAIT_CYCLES cycles for reads (3 for writes, WAIT_CYCLES = 0).
- The non-granted requester sees ack = 0 and must keep req asserted (stall).
- A req still high in the cycle after its ack is a new request.
- Request dropped before ack: the transaction still completes from the latched fields and ack still pulses; no hang.
- Request inputs changing mid-transaction have no effect: fields are latched.
- mem_we is never 1 for more than one cycle per transaction.
- mem_we and mem_re are never both 1.
- rdata registers keep their value until the next read completes for that port.

Optional Feature:
- Macro: MIPS_MEM_ARB_LDR_LOCK_EN.
- Defined:
  - Adds input port ldr_lock (1 bit).
  - While ldr_lock = 1, IDLE grants only the loader and cpu_req is ignored: the CPU stalls and the program download is exclusive.
  - Asserting lock mid-CPU-transaction does not abort it; the CPU transaction completes first.
  - Deasserting lock restores round-robin, with last_owner as updated.
- Undefined: no ldr_lock port; pure round-robin.

Decomposition:
- Package mips_mem_pkg:
  - typedef enum owner_e {OWN_CPU, OWN_LDR}.
  - typedef enum arb_state_e {ARB_IDLE, ARB_ACCESS, ARB_WAIT, ARB_DONE}.
  - Default width constants.
- One sub-module: mips_mem_rr_pick, a two-requester round-robin picker. Inputs: req[1:0], last_owner, and lock when compiled in. Outputs: grant_valid, grant_owner.
- The FSM, wait counter and latch registers stay in the top level.

Test Plan:
- CPU read, WAIT_CYCLES = 1, addr 0x0000_0010, memory word 0xDEADBEEF -> mem_re high for 2 cycles; cpu_ack pulses at cycle 3 with cpu_rdata = 0xDEADBEEF; ldr_ack stays 0.
- Loader write, addr 0x0000_0004, data 0x2008_0005 -> mem_we high for exactly 1 cycle with matching addr/data; ldr_ack at cycle 2; a subsequent CPU read of 0x4 returns 0x2008_0005.
- cpu_req and ldr_req held simultaneously from reset -> grants alternate CPU, LDR, CPU, LDR across 4 transactions; each ack is a single-cycle pulse.
- Reset asserted during WAIT of a CPU read -> all outputs 0 immediately; after release, the CPU (still requesting) is granted first and its read completes normally.
- WAIT_CYCLES = 0 and WAIT_CYCLES = 3 builds -> read latency exactly 2 and 5 cycles; a CPU req dropped during ACCESS still produces a cpu_ack pulse.
- MIPS_MEM_ARB_LDR_LOCK_EN defined, ldr_lock = 1 with both requesting -> 4 consecutive loader grants and cpu_ack = 0 throughout; lock released -> the next grant goes to the CPU.
